frame_update_arbiter: RTL and testbench

//  Owns the 16x12 brick bitmap that feeds VGAdisplay.data. Game-logic requesters (ball,

---
 rtl/frame_update_arbiter.sv | 157 +++++++++++++++
 tb/tb_frame_update_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_update_arbiter.sv
// Owns the shadow and displayed brick bitmaps: round-robin single-cell writes and a
// row-sequential clear go to the shadow, which is copied to the display at vSync fall.
module frame_update_arbiter #(
    parameter int N_REQ = 3,
    parameter int COLS  = 16,
    parameter int ROWS  = 12
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [4*N_REQ-1:0]     wr_x,
    input  logic [4*N_REQ-1:0]     wr_y,
    input  logic [N_REQ-1:0]       wr_val,
    output logic [N_REQ-1:0]       gnt,
    input  logic                   clear_req,
    output logic                   clear_busy,
    input  logic                   vsync_in,
    output logic [COLS*ROWS-1:0]   frame_data,
    output logic                   commit,
    output logic [7:0]             frame_id,
    output logic                   drop_err
);
    localparam int NBITS = COLS * ROWS;
    localparam int PW    = $clog2(N_REQ);
    localparam int RW    = $clog2(ROWS);
    localparam int BW    = $clog2(NBITS);
    localparam int XW    = $clog2(4 * N_REQ);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_COMMIT} state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [PW-1:0]        r_ptr;
    logic [NBITS-1:0]     r_shadow;
    logic [NBITS-1:0]     r_frame;
    logic                 r_commit;
    logic [7:0]           r_fid;
    logic                 r_drop;
    logic [RW-1:0]        r_row;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_sync3;
    logic                 r_pending;

    logic                 w_vs_fall;
    logic                 w_gnt_any;
    logic [PW-1:0]        w_gnt_idx;
    logic [PW-1:0]        w_cand;
    logic [N_REQ-1:0]     w_gnt;
    logic [XW-1:0]        w_sel_base;
    logic [3:0]           w_sel_x;
    logic [3:0]           w_sel_y;
    logic                 w_sel_val;
    logic                 w_in_range;
    logic [BW-1:0]        w_bit;
    logic [BW-1:0]        w_row_base;

    // Third flop only remembers the previous synchronised level for edge detection.
    assign w_vs_fall = r_sync3 & ~r_sync2;

    // Grants only in IDLE with no clear or commit competing; search starts after r_ptr.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        w_gnt     = '0;
        if (r_state == S_IDLE && !clear_req && !r_pending) begin
            for (int k = 1; k <= N_REQ; k++) begin
                w_cand = PW'((int'(r_ptr) + k) % N_REQ);
                if (!w_gnt_any && req[w_cand]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = w_cand;
                end
            end
            if (w_gnt_any) w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    assign w_sel_base = XW'(4 * int'(w_gnt_idx));
    assign w_sel_x    = wr_x[w_sel_base +: 4];
    assign w_sel_y    = wr_y[w_sel_base +: 4];
    assign w_sel_val  = wr_val[w_gnt_idx];
    assign w_in_range = (int'(w_sel_x) < COLS) && (int'(w_sel_y) < ROWS);
    assign w_bit      = BW'(NBITS - 1 - (int'(w_sel_y) * COLS + int'(w_sel_x)));
    assign w_row_base = BW'(NBITS - COLS * (int'(r_row) + 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (clear_req)      w_next_state = S_CLEAR;
                else if (r_pending) w_next_state = S_COMMIT;
            end
            S_CLEAR:  if (r_row == RW'(ROWS - 1)) w_next_state = S_IDLE;
            S_COMMIT: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr     <= PW'(N_REQ - 1);
            r_shadow  <= '0;
            r_frame   <= '0;
            r_commit  <= 1'b0;
            r_fid     <= '0;
            r_drop    <= 1'b0;
            r_row     <= '0;
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_sync3   <= 1'b1;
            r_pending <= 1'b0;
        end else begin
            r_sync1  <= vsync_in;
            r_sync2  <= r_sync1;
            r_sync3  <= r_sync2;
            r_commit <= 1'b0;
            r_drop   <= 1'b0;
            // A fall arriving during the commit cycle must survive to force another commit.
            if (w_vs_fall)                r_pending <= 1'b1;
            else if (r_state == S_COMMIT) r_pending <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clear_req) begin
                        r_row <= '0;
                    end else if (w_gnt_any) begin
                        r_ptr <= w_gnt_idx;
                        if (w_in_range) r_shadow[w_bit] <= w_sel_val;
                        else            r_drop <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_shadow[w_row_base +: COLS] <= '0;
                    r_row <= r_row + 1'b1;
                end
                S_COMMIT: begin
                    r_frame  <= r_shadow;
                    r_commit <= 1'b1;
                    r_fid    <= r_fid + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign gnt        = w_gnt;
    assign clear_busy = (r_state == S_CLEAR);
    assign frame_data = r_frame;
    assign commit     = r_commit;
    assign frame_id   = r_fid;
    assign drop_err   = r_drop;
endmodule

// File: tb/tb_frame_update_arbiter.sv
// Bench for frame_update_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a cell-array model of the shadow/display bitmaps.
module tb_frame_update_arbiter;
    localparam int N    = 3;
    localparam int COLS = 16;
    localparam int ROWS = 12;
    localparam int NB   = COLS * ROWS;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [4*N-1:0]  wr_x;
    logic [4*N-1:0]  wr_y;
    logic [N-1:0]    wr_val;
    logic [N-1:0]    gnt;
    logic            clear_req;
    logic            clear_busy;
    logic            vsync_in;
    logic [NB-1:0]   frame_data;
    logic            commit;
    logic [7:0]      frame_id;
    logic            drop_err;

    frame_update_arbiter #(.N_REQ(N), .COLS(COLS), .ROWS(ROWS)) dut (
        .clock(clock), .reset(reset), .req(req), .wr_x(wr_x), .wr_y(wr_y),
        .wr_val(wr_val), .gnt(gnt), .clear_req(clear_req), .clear_busy(clear_busy),
        .vsync_in(vsync_in), .frame_data(frame_data), .commit(commit),
        .frame_id(frame_id), .drop_err(drop_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: bitmaps as [y][x] cells, engine activity as counters.
    bit   m_shadow [ROWS][COLS];
    bit   m_disp   [ROWS][COLS];
    int   m_ptr, m_clear_left, m_clear_row, m_fid;
    bit   m_commit_now, m_pending, m_commit_out, m_drop_out;
    bit   m_vs [3];
    logic [N-1:0] last_gnt = '0;
    int   gnt_log[$];
    int   commit_seen = 0, drop_seen = 0, busy_seen = 0;

    function automatic logic [NB-1:0] pack_disp();
        logic [NB-1:0] v;
        v = '0;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                v[NB-1-(y*COLS+x)] = m_disp[y][x];
        return v;
    endfunction

    task automatic model_reset();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                m_shadow[y][x] = 1'b0;
                m_disp[y][x]   = 1'b0;
            end
        m_ptr = N - 1; m_clear_left = 0; m_clear_row = 0; m_fid = 0;
        m_commit_now = 0; m_pending = 0; m_commit_out = 0; m_drop_out = 0;
        for (int i = 0; i < 3; i++) m_vs[i] = 1'b1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clock);
            if (!reset) begin
                model_reset();
                chk("reset_outs", NB'({gnt, clear_busy, commit, frame_id, drop_err}), '0);
                chk("reset_frame", frame_data, '0);
                last_gnt = '0;
            end else begin
                int  gi, x, y;
                bit  fall, was_commit;
                logic [N-1:0] eg;
                gi = -1;
                eg = '0;
                if (m_clear_left == 0 && !m_commit_now && !clear_req && !m_pending)
                    for (int k = 1; k <= N; k++)
                        if (gi < 0 && req[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
                if (gi >= 0) eg[gi] = 1'b1;
                chk("gnt", NB'(gnt), NB'(eg));
                chk("clear_busy", NB'(clear_busy), NB'(m_clear_left > 0));
                chk("commit", NB'(commit), NB'(m_commit_out));
                chk("frame_id", NB'(frame_id), NB'(m_fid));
                chk("drop_err", NB'(drop_err), NB'(m_drop_out));
                chk("frame_data", frame_data, pack_disp());
                last_gnt = gnt;
                for (int i = 0; i < N; i++) if (gnt[i]) gnt_log.push_back(i);
                commit_seen += int'(commit);
                drop_seen   += int'(drop_err);
                busy_seen   += int'(clear_busy);

                fall = m_vs[2] && !m_vs[1];
                m_vs[2] = m_vs[1]; m_vs[1] = m_vs[0]; m_vs[0] = vsync_in;
                was_commit = m_commit_now;
                m_commit_out = 0;
                m_drop_out   = 0;
                if (m_clear_left > 0) begin
                    for (int c = 0; c < COLS; c++) m_shadow[m_clear_row][c] = 1'b0;
                    m_clear_row++;
                    m_clear_left--;
                end else if (m_commit_now) begin
                    m_disp = m_shadow;
                    m_fid = (m_fid + 1) % 256;
                    m_commit_out = 1;
                    m_commit_now = 0;
                end else if (clear_req) begin
                    m_clear_left = ROWS;
                    m_clear_row  = 0;
                end else if (m_pending) begin
                    m_commit_now = 1;
                end else if (gi >= 0) begin
                    m_ptr = gi;
                    x = int'(wr_x[4*gi +: 4]);
                    y = int'(wr_y[4*gi +: 4]);
                    if (x < COLS && y < ROWS) m_shadow[y][x] = wr_val[gi];
                    else                      m_drop_out = 1;
                end
                if (fall)            m_pending = 1;
                else if (was_commit) m_pending = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input int x, input int y, input bit v);
        req[i] = 1'b1;
        wr_x[4*i +: 4] = 4'(x);
        wr_y[4*i +: 4] = 4'(y);
        wr_val[i] = v;
    endtask

    task automatic wait_gnt(input int i);
        bit ok;
        ok = 0;
        for (int t = 0; t < 20 && !ok; t++) begin
            tick();
            if (last_gnt[i]) ok = 1;
        end
        req[i] = 1'b0;
        chk("gnt_wait", NB'(ok), NB'(1));
    endtask

    task automatic commit_frame();
        vsync_in = 1'b0;
        repeat (3) tick();
        vsync_in = 1'b1;
        repeat (6) tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req = '0; clear_req = 1'b0; vsync_in = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        int c0, d0, b0, f0, g0, vs_left;
        int n [N];
        logic [NB-1:0] ones;
        ones = '1;
        reset = 1'b0; req = '0; wr_x = '0; wr_y = '0; wr_val = '0;
        clear_req = 1'b0; vsync_in = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // 1: single write then commit
        c0 = commit_seen;
        set_req(0, 0, 0, 1'b1);
        wait_gnt(0);
        commit_frame();
        chk("t1_bit191", NB'(frame_data[NB-1]), NB'(1));
        chk("t1_frame_id", NB'(frame_id), NB'(1));
        chk("t1_commits", NB'(commit_seen - c0), NB'(1));

        // 2: three requesters held, two writes each
        do_reset();
        g0 = gnt_log.size();
        for (int i = 0; i < N; i++) begin n[i] = 0; set_req(i, i, 2, 1'b1); end
        repeat (6) begin
            tick();
            for (int i = 0; i < N; i++)
                if (req[i] && last_gnt[i]) begin
                    n[i]++;
                    if (n[i] >= 2) req[i] = 1'b0;
                    else set_req(i, i + 3*n[i], 2, 1'b1);
                end
        end
        req = '0;
        chk("t2_ngrants", NB'(gnt_log.size() - g0), NB'(6));
        for (int j = 0; j < 6; j++)
            chk("t2_order", NB'(gnt_log[g0 + j]), NB'(j % 3));
        commit_frame();
        chk("t2_cells", NB'(frame_data[159:154]), NB'(6'h3f));
        chk("t2_count", NB'($countones(frame_data)), NB'(6));

        // 3: bottom-right cell and an out-of-range row
        set_req(1, 15, 11, 1'b1);
        wait_gnt(1);
        commit_frame();
        chk("t3_bit0", NB'(frame_data[0]), NB'(1));
        d0 = drop_seen;
        set_req(1, 3, 12, 1'b1);
        wait_gnt(1);
        repeat (2) tick();
        chk("t3_drop", NB'(drop_seen - d0), NB'(1));
        commit_frame();
        chk("t3_count", NB'($countones(frame_data)), NB'(7));

        // 4: fill all ones, clear, vsync during clear
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                set_req(0, x, y, 1'b1);
                wait_gnt(0);
            end
        commit_frame();
        chk("t4_full", frame_data, ones);
        c0 = commit_seen; b0 = busy_seen;
        clear_req = 1'b1; tick(); clear_req = 1'b0;
        tick();
        vsync_in = 1'b0; repeat (3) tick(); vsync_in = 1'b1;
        repeat (16) tick();
        chk("t4_busy", NB'(busy_seen - b0), NB'(12));
        chk("t4_commits", NB'(commit_seen - c0), NB'(1));
        chk("t4_empty", frame_data, '0);

        // 5: two vsync falls merged during a clear
        c0 = commit_seen; f0 = int'(frame_id);
        clear_req = 1'b1; tick(); clear_req = 1'b0;
        vsync_in = 1'b0; repeat (2) tick(); vsync_in = 1'b1; repeat (2) tick();
        vsync_in = 1'b0; repeat (2) tick(); vsync_in = 1'b1;
        repeat (16) tick();
        chk("t5_commits", NB'(commit_seen - c0), NB'(1));
        chk("t5_frame_id", NB'(frame_id), NB'((f0 + 1) % 256));

        // 6: reset at clear row 5, then pointer restart
        set_req(0, 1, 1, 1'b1); wait_gnt(0);
        commit_frame();
        clear_req = 1'b1; tick(); clear_req = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        #2;
        chk("t6_async_outs", NB'({gnt, clear_busy, commit, frame_id, drop_err}), '0);
        chk("t6_async_frame", frame_data, '0);
        tick();
        reset = 1'b1;
        tick();
        set_req(1, 2, 2, 1'b1);
        set_req(2, 3, 3, 1'b1);
        #1;
        chk("t6_first_gnt", NB'(gnt), NB'(3'b010));
        wait_gnt(1);
        wait_gnt(2);

        // randomized traffic
        vs_left = $urandom_range(20, 60);
        for (int cyc = 0; cyc < 2500; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && last_gnt[i]) req[i] = 1'b0;
                if (!req[i] && $urandom_range(0, 2) == 0)
                    set_req(i, $urandom_range(0, 15),
                            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 11),
                            1'($urandom_range(0, 1)));
            end
            clear_req = ($urandom_range(0, 79) == 0);
            vs_left--;
            if (vs_left <= 0) begin
                vsync_in = ~vsync_in;
                vs_left = vsync_in ? $urandom_range(20, 60) : $urandom_range(3, 8);
            end
            tick();
        end
        req = '0; clear_req = 1'b0;
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
